// File: rtl/drive_sync_fifo.sv
// drive_sync_fifo: brings a self-timed drive/free handshake and its data word into the clk
// domain through a first-word-fall-through FIFO. DRIVE_SYNC_FIFO_STALL_CNT_EN adds o_stall_cnt.
module drive_sync_fifo #(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_drive,
    input  logic [DATA_WIDTH-1:0]       i_data,
    output logic                        o_free,
    output logic                        o_valid,
    output logic [DATA_WIDTH-1:0]       o_data,
    input  logic                        i_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_count
`ifdef DRIVE_SYNC_FIFO_STALL_CNT_EN
    ,
    output logic [15:0]                 o_stall_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_FREE       = 2'd2
    } state_e;

    logic                   tog_q, tog_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   req_evt_q, req_evt_d;

    state_e                 state_q, state_d;
    logic                   free_q, free_d;

    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   valid_q, valid_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;

    logic                   space;
    logic                   push;
    logic                   pop;

    // Drive event flips a toggle in the i_drive domain; only its level crosses into clk.
    always_comb tog_d = ~tog_q;

    always_ff @(posedge i_drive or negedge rst) begin
        if (!rst) tog_q <= 1'b0;
        else      tog_q <= tog_d;
    end

    // Synchronizer, then registered edge detect giving a one-cycle request event.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], tog_q};
        prev_d    = sync_q[SYNC_STAGES-1];
        req_evt_d = sync_q[SYNC_STAGES-1] ^ prev_q;
    end

    always_comb begin
        space   = (count_q < CNT_W'(FIFO_DEPTH));
        pop     = valid_q & i_ready;
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_evt_q) begin
                    if (space) begin
                        push    = 1'b1;
                        state_d = ST_FREE;
                    end else begin
                        state_d = ST_WAIT_SPACE;
                    end
                end
            end
            ST_WAIT_SPACE: begin
                // Space is judged on registered count, so a pop while full defers the write.
                if (space) begin
                    push    = 1'b1;
                    state_d = ST_FREE;
                end
            end
            ST_FREE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        free_d = (state_d == ST_FREE);
    end

    // FIFO storage; the head is re-registered so o_data holds its last value when empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != CNT_W'(0));
        data_d  = valid_d ? mem_d[rd_ptr_d] : data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            req_evt_q <= 1'b0;
            state_q   <= ST_IDLE;
            free_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            req_evt_q <= req_evt_d;
            state_q   <= state_d;
            free_q    <= free_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            mem_q     <= mem_d;
        end
    end

`ifdef DRIVE_SYNC_FIFO_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles spent waiting for FIFO space.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_WAIT_SPACE) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_q <= 16'd0;
        else      stall_q <= stall_d;
    end

    assign o_stall_cnt = stall_q;
`endif

    assign o_free  = free_q;
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_drive_sync_fifo.sv
// Self-checking bench for drive_sync_fifo: directed scenarios plus a randomized run
// checked against a queue model of the FIFO contents.
module tb_drive_sync_fifo;

    localparam int unsigned DW    = 128;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_drive;
    logic [DW-1:0] i_data;
    logic          o_free;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready;
    logic [CW-1:0] o_count;
`ifdef DRIVE_SYNC_FIFO_STALL_CNT_EN
    logic [15:0]   o_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq [$];
    bit            pend;
    logic [DW-1:0] pend_data;
    bit            free_seen;

    always #5 clk = ~clk;

    drive_sync_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_drive(i_drive),
        .i_data (i_data),
        .o_free (o_free),
        .o_valid(o_valid),
        .o_data (o_data),
        .i_ready(i_ready),
        .o_count(o_count)
`ifdef DRIVE_SYNC_FIFO_STALL_CNT_EN
        ,
        .o_stall_cnt(o_stall_cnt)
`endif
    );

    // Issue one async drive pulse mid-cycle, holding the word until it is freed.
    task automatic pulse_drive(input logic [DW-1:0] d);
        @(negedge clk);
        i_data    = d;
        pend      = 1'b1;
        pend_data = d;
        i_drive   = 1'b1;
        #2;
        i_drive   = 1'b0;
    endtask

    // Advance one clock; model pops if a head was presented with ready, pushes on free.
    task automatic step();
        bit do_pop;
        do_pop = (mq.size() != 0) && (i_ready == 1'b1);
        @(posedge clk);
        #1;
        if (do_pop) void'(mq.pop_front());
        free_seen = (o_free === 1'b1);
        if (free_seen && pend) begin
            mq.push_back(pend_data);
            pend = 1'b0;
        end
    endtask

    task automatic wait_free(input int lim, output int edges);
        edges = -1;
        for (int e = 1; e <= lim; e++) begin
            step();
            if (free_seen) begin
                edges = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        i_drive = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        pend    = 1'b0;
        mq.delete();
        repeat (3) @(posedge clk);
        #1;
        total++; if (o_free !== 1'b0) begin bad++; $display("FAIL reset_free got=%b exp=0", o_free); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        total++; if (o_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        total++; if (o_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", o_data); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [DW-1:0] a5;
        int n;
        a5 = {16{8'hA5}};
        i_ready = 1'b1;
        pulse_drive(a5);
        wait_free(20, n);
        total++; if (n != 4) begin bad++; $display("FAIL single_latency got=%0d exp=4", n); end
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", o_valid); end
        total++; if (o_data !== a5) begin bad++; $display("FAIL single_data got=%h exp=%h", o_data, a5); end
        total++; if (o_count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", o_count); end
        step();
        total++; if (o_free !== 1'b0) begin bad++; $display("FAIL single_free_width got=%b exp=0", o_free); end
        total++; if (o_count !== 3'd0) begin bad++; $display("FAIL single_count_after got=%0d exp=0", o_count); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL single_valid_after got=%b exp=0", o_valid); end
    endtask

    task automatic test_fill();
        int n;
        i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            pulse_drive(128'(k));
            wait_free(20, n);
            total++; if (n != 4) begin bad++; $display("FAIL fill_latency word=%0d got=%0d exp=4", k, n); end
        end
        total++; if (o_count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", o_count); end
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (o_valid !== 1'b1 || o_data !== 128'(k)) begin
                bad++; $display("FAIL fill_order got=%b/%0h exp=1/%0h", o_valid, o_data, k);
            end
            step();
        end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL fill_empty_valid got=%b exp=0", o_valid); end
        total++; if (o_count !== 3'd0) begin bad++; $display("FAIL fill_empty_count got=%0d exp=0", o_count); end
    endtask

    task automatic test_backpressure();
        int n;
        int frees;
        i_ready = 1'b0;
        for (int k = 11; k <= 14; k++) begin
            pulse_drive(128'(k));
            wait_free(20, n);
        end
        total++; if (o_count !== 3'd4) begin bad++; $display("FAIL bp_full_count got=%0d exp=4", o_count); end
        pulse_drive(128'(15));
        frees = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (free_seen) frees++;
        end
        total++; if (frees != 0) begin bad++; $display("FAIL bp_free_while_full got=%0d exp=0", frees); end
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        total++; if (free_seen || o_count !== 3'd3) begin bad++; $display("FAIL bp_pop_edge free=%b count=%0d exp=0/3", free_seen, o_count); end
        step();
        total++; if (!free_seen || o_count !== 3'd4) begin bad++; $display("FAIL bp_write_edge free=%b count=%0d exp=1/4", free_seen, o_count); end
`ifdef DRIVE_SYNC_FIFO_STALL_CNT_EN
        total++; if (o_stall_cnt !== 16'd10) begin bad++; $display("FAIL bp_stall_cnt got=%0d exp=10", o_stall_cnt); end
`endif
        i_ready = 1'b1;
        for (int k = 12; k <= 15; k++) begin
            total++;
            if (o_valid !== 1'b1 || o_data !== 128'(k)) begin
                bad++; $display("FAIL bp_order got=%b/%0h exp=1/%0h", o_valid, o_data, k);
            end
            step();
        end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", o_valid); end
    endtask

    task automatic test_push_pop();
        int n;
        int frees;
        i_ready = 1'b0;
        pulse_drive(128'(21));
        wait_free(20, n);
        pulse_drive(128'(22));
        wait_free(20, n);
        total++; if (o_count !== 3'd2) begin bad++; $display("FAIL pp_pre_count got=%0d exp=2", o_count); end
        pulse_drive(128'(23));
        frees = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (free_seen) frees++;
        end
        i_ready = 1'b1;
        step();
        total++; if (frees != 0 || !free_seen) begin bad++; $display("FAIL pp_free_timing early=%0d at4=%b exp=0/1", frees, free_seen); end
        total++; if (o_count !== 3'd2) begin bad++; $display("FAIL pp_count got=%0d exp=2", o_count); end
        for (int k = 22; k <= 23; k++) begin
            total++;
            if (o_valid !== 1'b1 || o_data !== 128'(k)) begin
                bad++; $display("FAIL pp_order got=%b/%0h exp=1/%0h", o_valid, o_data, k);
            end
            step();
        end
        total++; if (o_count !== 3'd0) begin bad++; $display("FAIL pp_empty got=%0d exp=0", o_count); end
    endtask

    task automatic test_reset_mid();
        int n;
        int frees;
        i_ready = 1'b0;
        pulse_drive(128'(33));
        step();
        rst = 1'b0;
        pend = 1'b0;
        mq.delete();
        repeat (2) @(posedge clk);
        #1;
        total++; if (o_count !== 3'd0 || o_valid !== 1'b0 || o_free !== 1'b0) begin
            bad++; $display("FAIL mid_reset_state count=%0d valid=%b free=%b exp=0/0/0", o_count, o_valid, o_free);
        end
        @(negedge clk);
        rst = 1'b1;
        frees = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (free_seen) frees++;
        end
        total++; if (frees != 0) begin bad++; $display("FAIL mid_reset_free got=%0d exp=0", frees); end
        total++; if (o_count !== 3'd0) begin bad++; $display("FAIL mid_reset_count got=%0d exp=0", o_count); end
        i_ready = 1'b1;
        pulse_drive(128'(44));
        wait_free(20, n);
        total++; if (n != 4) begin bad++; $display("FAIL mid_reset_next_latency got=%0d exp=4", n); end
        total++; if (o_data !== 128'(44)) begin bad++; $display("FAIL mid_reset_next_data got=%0h exp=2c", o_data); end
        step();
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        bit done;
        for (int w = 0; w < 40; w++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                i_ready = ($urandom_range(0, 3) == 0);
                step();
                total++; if (free_seen) begin bad++; $display("FAIL rnd_spurious_free word=%0d", w); end
            end
            d = {$urandom, $urandom, $urandom, $urandom};
            pulse_drive(d);
            done = 1'b0;
            for (int s = 0; s < 80 && !done; s++) begin
                i_ready = ($urandom_range(0, 3) == 0);
                step();
                done = free_seen;
                total++;
                if (o_count !== CW'(mq.size()) || o_valid !== (mq.size() != 0)) begin
                    bad++; $display("FAIL rnd_occupancy count=%0d valid=%b exp=%0d", o_count, o_valid, mq.size());
                end
                if (mq.size() != 0) begin
                    total++;
                    if (o_data !== mq[0]) begin bad++; $display("FAIL rnd_head got=%h exp=%h", o_data, mq[0]); end
                end
            end
            total++; if (!done) begin bad++; $display("FAIL rnd_free_timeout word=%0d", w); end
        end
        i_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            if (mq.size() != 0) begin
                total++;
                if (o_valid !== 1'b1 || o_data !== mq[0]) begin bad++; $display("FAIL rnd_drain got=%h exp=%h", o_data, mq[0]); end
            end
            step();
        end
        total++; if (o_count !== 3'd0 || mq.size() != 0) begin bad++; $display("FAIL rnd_final_count got=%0d model=%0d exp=0", o_count, mq.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
